// File: rtl/timer_sequencer.sv
// Command-driven master for a 16-bit Avalon-MM interval timer: programs start/stop,
// reads counter snapshots, and acknowledges timeouts while counting them.
module timer_sequencer #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [31:0]        cmd_period,
  input  logic               cmd_continuous,
  input  logic               cmd_irq_en,
  output logic [2:0]         tm_address,
  output logic               tm_chipselect,
  output logic               tm_write_n,
  output logic [15:0]        tm_writedata,
  input  logic [15:0]        tm_readdata,
  input  logic               tm_irq,
  output logic               tick,
  output logic [COUNT_W-1:0] tick_count,
  output logic               running,
  output logic               irq_out,
  output logic               snap_valid,
  output logic [31:0]        snap_value
);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PL, W_PH, W_CTRL, ACK, ACK_WAIT, S_WR, S_RDL, S_RDH, S_CAP
  } state_t;

  state_t             state, state_next;
  logic [31:0]        period_q;
  logic               cont_q, irq_en_q, start_q;
  logic [COUNT_W-1:0] count_q;
  logic               running_q;
  logic [15:0]        snap_lo_q;
  logic [31:0]        snap_q;
  logic               accept;

  assign accept     = cmd_valid && cmd_ready;
  assign tick_count = count_q;
  assign running    = running_q;
  assign irq_out    = tick && irq_en_q;
  // High half arrives in S_CAP; present it directly so snap_value is current with snap_valid.
  assign snap_value = (state == S_CAP) ? {tm_readdata, snap_lo_q} : snap_q;

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_address    = '0;
    tm_writedata  = '0;
    tick          = 1'b0;
    snap_valid    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !tm_irq;
        if (tm_irq) begin
          state_next = ACK;
        end else if (cmd_valid) begin
          case (cmd_op)
            2'd0, 2'd1: state_next = W_STOP;
            2'd2:       state_next = S_WR;
            default:    state_next = IDLE;
          endcase
        end
      end
      W_STOP: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd1;
        tm_writedata  = 16'h0008;
        state_next    = start_q ? W_PL : IDLE;
      end
      W_PL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd2;
        tm_writedata  = period_q[15:0];
        state_next    = W_PH;
      end
      W_PH: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd3;
        tm_writedata  = period_q[31:16];
        state_next    = W_CTRL;
      end
      W_CTRL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd1;
        tm_writedata  = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
        state_next    = IDLE;
      end
      ACK: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd0;
        tick          = 1'b1;
        state_next    = ACK_WAIT;
      end
      ACK_WAIT: state_next = IDLE;
      S_WR: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = 3'd4;
        state_next    = S_RDL;
      end
      S_RDL: begin
        tm_chipselect = 1'b1;
        tm_address    = 3'd4;
        state_next    = S_RDH;
      end
      S_RDH: begin
        tm_chipselect = 1'b1;
        tm_address    = 3'd5;
        state_next    = S_CAP;
      end
      S_CAP: begin
        snap_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      period_q  <= '0;
      cont_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      start_q   <= 1'b0;
      count_q   <= '0;
      running_q <= 1'b0;
      snap_lo_q <= '0;
      snap_q    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept && cmd_op == 2'd0) begin
        period_q <= (cmd_period == '0) ? 32'd1 : cmd_period;
        cont_q   <= cmd_continuous;
        irq_en_q <= cmd_irq_en;
      end
      if (state == IDLE && accept && (cmd_op == 2'd0 || cmd_op == 2'd1))
        start_q <= (cmd_op == 2'd0);
      case (state)
        W_STOP: if (!start_q) running_q <= 1'b0;
        W_CTRL: begin
          running_q <= 1'b1;
          count_q   <= '0;
        end
        ACK: begin
          count_q <= count_q + COUNT_W'(1);
          if (!cont_q) running_q <= 1'b0;
        end
        S_RDH: snap_lo_q <= tm_readdata;
        S_CAP: snap_q    <= {tm_readdata, snap_lo_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer: stimulus pushes expected bus/tick/snap events,
// a negedge monitor pops and compares them; includes a small timer slave model.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous, cmd_irq_en;
  logic [2:0]  tm_address;
  logic        tm_chipselect, tm_write_n;
  logic [15:0] tm_writedata, tm_readdata;
  logic        tm_irq;
  logic        tick, running, irq_out, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snap_value;

  timer_sequencer #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_irq_en(cmd_irq_en), .tm_address(tm_address), .tm_chipselect(tm_chipselect),
    .tm_write_n(tm_write_n), .tm_writedata(tm_writedata), .tm_readdata(tm_readdata),
    .tm_irq(tm_irq), .tick(tick), .tick_count(tick_count), .running(running),
    .irq_out(irq_out), .snap_valid(snap_valid), .snap_value(snap_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timer slave model: readdata one cycle after a read, snapshot latched on write to 4/5,
  // interrupt level cleared by a status write.
  int          irq_raised_n = 0;
  int          irq_cleared_n = 0;
  logic        irq_force = 1'b0;
  logic [31:0] snap_src = '0;
  logic [31:0] snap_lat = '0;
  assign tm_irq = irq_force | (irq_raised_n != irq_cleared_n);

  always @(posedge clk) begin
    if (tm_chipselect && tm_write_n)
      tm_readdata <= (tm_address == 3'd4) ? snap_lat[15:0] :
                     (tm_address == 3'd5) ? snap_lat[31:16] : 16'h0;
    else
      tm_readdata <= 16'($urandom);
    if (tm_chipselect && !tm_write_n && (tm_address == 3'd4 || tm_address == 3'd5))
      snap_lat <= snap_src;
    if (tm_chipselect && !tm_write_n && tm_address == 3'd0)
      irq_cleared_n <= irq_raised_n;
  end

  typedef struct { int cyc; logic [2:0] addr; logic wr; logic [15:0] data; } bus_t;
  typedef struct { int cyc; logic [15:0] cnt; logic irq; } tick_t;
  typedef struct { int cyc; logic [31:0] val; } snap_t;
  bus_t  bus_q[$];
  tick_t tick_q[$];
  snap_t snap_q[$];

  // Reference model of the timer configuration as the sequencer should leave it.
  logic [15:0] m_count = '0;
  logic        m_running = 1'b0, m_cont = 1'b0, m_irqen = 1'b0;

  function automatic void push_bus(int c, logic [2:0] a, logic w, logic [15:0] d);
    bus_t b;
    b.cyc = c; b.addr = a; b.wr = w; b.data = d;
    bus_q.push_back(b);
  endfunction

  function automatic void model_start(int acc, logic [31:0] per, logic cont, logic ien);
    logic [31:0] p;
    p = (per == 0) ? 32'd1 : per;
    push_bus(acc + 1, 3'd1, 1'b1, 16'h0008);
    push_bus(acc + 2, 3'd2, 1'b1, p[15:0]);
    push_bus(acc + 3, 3'd3, 1'b1, p[31:16]);
    push_bus(acc + 4, 3'd1, 1'b1, 16'h0005 | (cont ? 16'h0002 : 16'h0000));
    m_cont = cont; m_irqen = ien; m_count = '0; m_running = 1'b1;
  endfunction

  function automatic void model_stop(int acc);
    push_bus(acc + 1, 3'd1, 1'b1, 16'h0008);
    m_running = 1'b0;
  endfunction

  function automatic void model_snap(int acc, logic [31:0] val);
    snap_t s;
    push_bus(acc + 1, 3'd4, 1'b1, 16'h0000);
    push_bus(acc + 2, 3'd4, 1'b0, 16'h0000);
    push_bus(acc + 3, 3'd5, 1'b0, 16'h0000);
    s.cyc = acc + 4; s.val = val;
    snap_q.push_back(s);
  endfunction

  function automatic void model_irq(int c);
    tick_t t;
    push_bus(c, 3'd0, 1'b1, 16'h0000);
    t.cyc = c; t.cnt = m_count; t.irq = m_irqen;
    tick_q.push_back(t);
    m_count = m_count + 16'd1;
    if (!m_cont) m_running = 1'b0;
  endfunction

  // Monitor: compares every bus access, tick and snapshot against the queues.
  bus_t  mb;
  tick_t mt;
  snap_t ms;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (tm_chipselect) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", {tm_address, tm_write_n, tm_writedata}, 32'hFFFF_FFFF);
        end else begin
          mb = bus_q.pop_front();
          if (mb.cyc >= 0) chk("bus_cycle", cyc, mb.cyc);
          chk("bus_addr", {29'b0, tm_address}, {29'b0, mb.addr});
          chk("bus_write", {31'b0, !tm_write_n}, {31'b0, mb.wr});
          if (mb.wr) chk("bus_wdata", {16'b0, tm_writedata}, {16'b0, mb.data});
        end
      end else begin
        chk("bus_idle", {tm_address, tm_write_n, tm_writedata}, {3'd0, 1'b1, 16'h0});
      end
      if (tick) begin
        if (tick_q.size() == 0) begin
          chk("tick_unexpected", {31'b0, tick}, 32'd0);
        end else begin
          mt = tick_q.pop_front();
          if (mt.cyc >= 0) chk("tick_cycle", cyc, mt.cyc);
          chk("tick_count_at_tick", {16'b0, tick_count}, {16'b0, mt.cnt});
          chk("irq_out", {31'b0, irq_out}, {31'b0, mt.irq});
        end
      end else if (irq_out) begin
        chk("irq_out_no_tick", {31'b0, irq_out}, 32'd0);
      end
      if (snap_valid) begin
        if (snap_q.size() == 0) begin
          chk("snap_unexpected", {31'b0, snap_valid}, 32'd0);
        end else begin
          ms = snap_q.pop_front();
          chk("snap_cycle", cyc, ms.cyc);
          chk("snap_value", snap_value, ms.val);
        end
      end
    end
  end

  // Drives a command from just after a posedge; returns the cycle of acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                          input logic ien, output int acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per;
    cmd_continuous = cont; cmd_irq_en = ien;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout actual=none required=accept");
    end else begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((bus_q.size() != 0 || tick_q.size() != 0 || snap_q.size() != 0) && n < 60) begin
      @(posedge clk); n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL settle_timeout actual=%0d/%0d/%0d required=0/0/0",
               bus_q.size(), tick_q.size(), snap_q.size());
      bus_q.delete(); tick_q.delete(); snap_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("tick_count", {16'b0, tick_count}, {16'b0, m_count});
    chk("running", {31'b0, running}, {31'b0, m_running});
  endtask

  task automatic raise_irq_idle();
    model_irq(cyc + 1);
    irq_raised_n++;
  endtask

  int          acc;
  logic [31:0] per;
  logic        cont, ien;
  int          r;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_period = '0;
    cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'b0, tm_chipselect}, 32'd0);
    chk("rst_wn", {31'b0, tm_write_n}, 32'd1);
    chk("rst_running", {31'b0, running}, 32'd0);
    chk("rst_tick_count", {16'b0, tick_count}, 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
    chk("rst_pulses", {29'b0, tick, irq_out, snap_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // START periodic with ready held low through the four writes
    send_cmd(2'd0, 32'h0001_0004, 1'b1, 1'b1, acc);
    if (acc >= 0) model_start(acc, 32'h0001_0004, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready_busy", {31'b0, cmd_ready}, (i < 4) ? 32'd0 : 32'd1);
    end
    settle();

    // Externally held irq for three cycles: one acknowledge only
    model_irq(cyc + 1);
    irq_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 irq_force = 1'b0;
    settle();

    // One-shot, timeout, then restart clears the count
    send_cmd(2'd0, 32'd5, 1'b0, 1'b0, acc);
    if (acc >= 0) model_start(acc, 32'd5, 1'b0, 1'b0);
    settle();
    raise_irq_idle();
    settle();
    chk("oneshot_count", {16'b0, tick_count}, 32'd1);
    chk("oneshot_stopped", {31'b0, running}, 32'd0);
    send_cmd(2'd0, 32'd5, 1'b0, 1'b0, acc);
    if (acc >= 0) model_start(acc, 32'd5, 1'b0, 1'b0);
    settle();

    // Snapshot
    snap_src = 32'h1234_BEEF;
    send_cmd(2'd2, 32'd0, 1'b0, 1'b0, acc);
    if (acc >= 0) model_snap(acc, 32'h1234_BEEF);
    settle();

    // Zero period clamp, then STOP
    send_cmd(2'd0, 32'd0, 1'b1, 1'b0, acc);
    if (acc >= 0) model_start(acc, 32'd0, 1'b1, 1'b0);
    settle();
    send_cmd(2'd1, 32'd0, 1'b0, 1'b0, acc);
    if (acc >= 0) model_stop(acc);
    settle();

    // Reset in W_PH
    send_cmd(2'd0, 32'hABCD_0123, 1'b1, 1'b1, acc);
    if (acc >= 0) model_start(acc, 32'hABCD_0123, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    bus_q.delete(); tick_q.delete(); snap_q.delete();
    m_count = '0; m_running = 1'b0; m_cont = 1'b0; m_irqen = 1'b0;
    #1;
    chk("midrst_cs", {31'b0, tm_chipselect}, 32'd0);
    chk("midrst_wn", {31'b0, tm_write_n}, 32'd1);
    chk("midrst_running", {31'b0, running}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // irq and command together: the acknowledge goes first
    raise_irq_idle();
    #1 chk("ready_irq", {31'b0, cmd_ready}, 32'd0);
    snap_src = 32'hCAFE_0042;
    send_cmd(2'd2, 32'd0, 1'b0, 1'b0, acc);
    if (acc >= 0) model_snap(acc, 32'hCAFE_0042);
    settle();

    // Randomized commands, timeouts in idle and timeouts arriving mid-sequence
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 4);
      per = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cont = 1'($urandom); ien = 1'($urandom);
      case (r)
        0: begin
          send_cmd(2'd0, per, cont, ien, acc);
          if (acc >= 0) model_start(acc, per, cont, ien);
        end
        1: begin
          send_cmd(2'd1, per, cont, ien, acc);
          if (acc >= 0) model_stop(acc);
        end
        2: begin
          snap_src = $urandom;
          send_cmd(2'd2, per, cont, ien, acc);
          if (acc >= 0) model_snap(acc, snap_src);
        end
        3: send_cmd(2'd3, per, cont, ien, acc);
        default: raise_irq_idle();
      endcase
      if (r <= 3 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        model_irq(-1);
        irq_raised_n++;
      end
      settle();
    end

    chk("queues_drained", bus_q.size() + tick_q.size() + snap_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
